// File: rtl/btn_pkg.sv
// Shared state encoding for the push-button debouncer and anything that decodes its state.
package btn_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARM_ON  = 2'd1;
    localparam logic [1:0] ST_HELD    = 2'd2;
    localparam logic [1:0] ST_ARM_OFF = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        ARM_ON  = ST_ARM_ON,
        HELD    = ST_HELD,
        ARM_OFF = ST_ARM_OFF
    } btn_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for slow asynchronous board inputs; synchronous active-high reset to 0.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            q  <= 1'b0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/btn_step_gen.sv
// Debounces one raw button into a level plus a one-cycle step pulse per press and a press counter.
// Define AUTO_REPEAT_EN to add auto-repeat step pulses while the button stays held.
//
// state   | meaning
// IDLE    | released, waiting for a synced high sample
// ARM_ON  | counting agreeing high samples before accepting a press
// HELD    | press accepted, level high
// ARM_OFF | counting agreeing low samples before accepting a release
module btn_step_gen
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 8,
    parameter int REPEAT_DELAY    = 20000,
    parameter int REPEAT_PERIOD   = 5000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn,
    output logic             step,
    output logic             level,
    output logic [CNT_W-1:0] press_cnt
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_chk_deb
        $error("btn_step_gen: DEBOUNCE_CYCLES must be at least 2");
    end
    // The repeat counter reloads to DELAY-PERIOD, so the delay must exceed the period.
    if (REPEAT_PERIOD < 1 || REPEAT_DELAY <= REPEAT_PERIOD) begin : g_chk_rep
        $error("btn_step_gen: need 1 <= REPEAT_PERIOD < REPEAT_DELAY");
    end

    logic            btn_s2;
    btn_state_t      state, state_nxt;
    logic [DW-1:0]   deb_cnt, deb_nxt;
    logic            press_evt;
    logic            step_nxt;
    logic            level_nxt;

    sync2 u_sync2 (
        .clk (clk),
        .rst (rst),
        .d   (btn),
        .q   (btn_s2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            deb_cnt <= '0;
        end else begin
            state   <= state_nxt;
            deb_cnt <= deb_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        deb_nxt   = deb_cnt;
        unique case (state)
            IDLE: begin
                if (btn_s2) begin
                    state_nxt = ARM_ON;
                    deb_nxt   = DW'(1);
                end
            end
            ARM_ON: begin
                if (!btn_s2) begin
                    state_nxt = IDLE;
                    deb_nxt   = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt = HELD;
                    deb_nxt   = '0;
                end else begin
                    deb_nxt = deb_cnt + DW'(1);
                end
            end
            HELD: begin
                if (!btn_s2) begin
                    state_nxt = ARM_OFF;
                    deb_nxt   = DW'(1);
                end
            end
            ARM_OFF: begin
                if (btn_s2) begin
                    state_nxt = HELD;
                    deb_nxt   = '0;
                end else if (deb_cnt == DEB_LAST) begin
                    state_nxt = IDLE;
                    deb_nxt   = '0;
                end else begin
                    deb_nxt = deb_cnt + DW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                deb_nxt   = '0;
            end
        endcase
    end

    // Only a fresh press triggers; ARM_OFF->HELD is release bounce.
    assign press_evt = (state == ARM_ON) && (state_nxt == HELD);

`ifdef AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY);
    localparam logic [RW-1:0] REP_LAST   = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] REP_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [RW-1:0] rep_cnt, rep_nxt;
    logic          held_stay;
    logic          rep_evt;

    assign held_stay = (state == HELD) && (state_nxt == HELD);
    assign rep_evt   = held_stay && (rep_cnt == REP_LAST);

    always_comb begin
        rep_nxt = '0;
        if (held_stay) begin
            rep_nxt = rep_evt ? REP_RELOAD : rep_cnt + RW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_nxt;
        end
    end
`endif

    always_comb begin
        step_nxt  = press_evt;
`ifdef AUTO_REPEAT_EN
        step_nxt  = press_evt | rep_evt;
`endif
        level_nxt = (state_nxt == HELD) || (state_nxt == ARM_OFF);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            step      <= 1'b0;
            level     <= 1'b0;
            press_cnt <= '0;
        end else begin
            step      <= step_nxt;
            level     <= level_nxt;
            press_cnt <= press_cnt + CNT_W'(step_nxt);
        end
    end

endmodule

// File: tb/tb_btn_step_gen.sv
// Self-checking bench for btn_step_gen: per-cycle comparison against a run-length debounce model
// plus directed scenarios with hand-computed latencies and counts.
module tb_btn_step_gen;

    localparam int D   = 4;
    localparam int CW  = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          btn = 1'b0;
    logic          step;
    logic          level;
    logic [CW-1:0] press_cnt;

    int n_cmp = 0;
    int n_err = 0;

    btn_step_gen #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (CW),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn       (btn),
        .step      (step),
        .level     (level),
        .press_cnt (press_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: level flips once D consecutive synced samples disagree with it; a rise is a press.
    logic       m_s1 = 1'b0, m_s2 = 1'b0;
    logic       m_lvl = 1'b0;
    int         m_run = 0;
    int         m_hcnt = 0;
    logic       m_step = 1'b0;
    logic [CW-1:0] m_cnt = '0;

    initial begin
        logic seen, was_held, now_held;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_s1 = 0; m_s2 = 0; m_lvl = 0; m_run = 0; m_hcnt = 0; m_step = 0; m_cnt = '0;
            end else begin
                seen = m_s2;
                m_s2 = m_s1;
                m_s1 = btn;
                was_held = m_lvl && (m_run == 0);
                m_step = 1'b0;
                if (seen != m_lvl) begin
                    m_run++;
                    if (m_run == D) begin
                        m_lvl = seen;
                        m_run = 0;
                        if (seen) m_step = 1'b1;
                    end
                end else begin
                    m_run = 0;
                end
                now_held = m_lvl && (m_run == 0);
`ifdef AUTO_REPEAT_EN
                if (was_held && now_held) begin
                    m_hcnt++;
                    if (m_hcnt >= RD && ((m_hcnt - RD) % RP) == 0) m_step = 1'b1;
                end else begin
                    m_hcnt = 0;
                end
`else
                m_hcnt = (was_held && now_held) ? m_hcnt + 1 : 0;
`endif
                m_cnt = m_cnt + CW'(m_step);
            end
            #1;
            check("cyc_step",  int'(step),      int'(m_step));
            check("cyc_level", int'(level),     int'(m_lvl));
            check("cyc_cnt",   int'(press_cnt), int'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Runs n cycles; returns pulse count and 1-based cycle of the first pulse (0 if none).
    task automatic run(input int n, output int pulses, output int first);
        pulses = 0;
        first  = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (step) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
    endtask

    task automatic press(input int hold, input int rel);
        int p, f;
        btn = 1'b1;
        run(hold, p, f);
        btn = 1'b0;
        run(rel, p, f);
    endtask

`ifdef AUTO_REPEAT_EN
    localparam int HOLD1 = 13;
`else
    localparam int HOLD1 = 20;
`endif

    initial begin
        int p, f, extra;
        int offs[$];
        int exp_offs[6];
        exp_offs[0] = 10; exp_offs[1] = 13; exp_offs[2] = 16;
        exp_offs[3] = 19; exp_offs[4] = 22; exp_offs[5] = 25;

        rst = 1'b1;
        btn = 1'b0;
        run(3, p, f);
        check("rst_step",  int'(step), 0);
        check("rst_level", int'(level), 0);
        check("rst_cnt",   int'(press_cnt), 0);
        rst = 1'b0;
        run(3, p, f);

        // Clean press
        btn = 1'b1;
        run(HOLD1, p, f);
        check("clean_latency", f, 6);
        check("clean_pulses",  p, 1);
        check("clean_level",   int'(level), 1);
        check("clean_cnt",     int'(press_cnt), 1);
        btn = 1'b0;
        run(10, p, f);
        check("clean_release_level", int'(level), 0);
        check("clean_release_pulses", p, 0);

        // Bouncing press
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            btn = (i % 2 == 0);
            tick();
            if (step) extra++;
        end
        btn = 1'b1;
        run(10, p, f);
        check("bounce_quiet",   extra, 0);
        check("bounce_latency", f, 6);
        check("bounce_pulses",  p, 1);
        check("bounce_cnt",     int'(press_cnt), 2);
        btn = 1'b0;
        run(10, p, f);

        // Glitch shorter than the debounce window
        btn = 1'b1;
        run(3, p, f);
        extra = p;
        btn = 1'b0;
        run(10, p, f);
        check("glitch_pulses", extra + p, 0);
        check("glitch_level",  int'(level), 0);
        check("glitch_cnt",    int'(press_cnt), 2);

        // Release bounce while held
        btn = 1'b1;
        run(9, p, f);
        check("relb_press", f, 6);
        btn = 1'b0;
        run(2, p, f);
        extra = p;
        btn = 1'b1;
        run(8, p, f);
        check("relb_pulses", extra + p, 0);
        check("relb_level",  int'(level), 1);
        check("relb_cnt",    int'(press_cnt), 3);
        btn = 1'b0;
        run(10, p, f);
        check("relb_release_level", int'(level), 0);

        // Wrap of press_cnt
        rst = 1'b1;
        run(2, p, f);
        rst = 1'b0;
        run(2, p, f);
        for (int k = 0; k < 15; k++) press(8, 8);
        check("wrap_15", int'(press_cnt), 15);
        press(8, 8);
        check("wrap_0", int'(press_cnt), 0);
        press(8, 8);
        check("wrap_1", int'(press_cnt), 1);

        // Reset while in ARM_ON
        btn = 1'b1;
        run(4, p, f);
        check("abort_prestep", p, 0);
        rst = 1'b1;
        btn = 1'b0;
        run(2, p, f);
        rst = 1'b0;
        run(12, p, f);
        check("abort_pulses", p, 0);
        check("abort_level",  int'(level), 0);
        check("abort_cnt",    int'(press_cnt), 0);

        // Long hold: auto-repeat pulses, or a single pulse without it
        btn = 1'b1;
        run(6, p, f);
        check("long_first", f, 6);
        for (int i = 1; i <= 25; i++) begin
            tick();
            if (step) offs.push_back(i);
        end
`ifdef AUTO_REPEAT_EN
        check("rep_count", offs.size(), 6);
        for (int i = 0; i < 6 && i < offs.size(); i++) check("rep_offset", offs[i], exp_offs[i]);
`else
        check("rep_count", offs.size(), 0);
`endif
        btn = 1'b0;
        run(10, p, f);
        check("long_release_level", int'(level), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
